// File: rtl/rs232_baud_ctrl.sv
// Auto-baud calibration sequencer: arms the measurement core, averages 2^NB_MEAS_LOG2 start-bit samples
// and publishes a locked divisor or an error. Optional macro RS232_BAUD_CTRL_AUTORETRY_EN re-arms from ERR after RETRY_WAIT cycles.
module rs232_baud_ctrl #(
  parameter int unsigned NB_MEAS_LOG2 = 2,
  parameter logic [3:0]  PRESC        = 4'd3,
  parameter logic [11:0] TOL          = 12'd2,
  parameter logic [11:0] MIN_DIV      = 12'd4,
  parameter logic [23:0] TIMEOUT      = 24'd10_000_000,
  parameter bit          AUTO_START   = 1'b1
`ifdef RS232_BAUD_CTRL_AUTORETRY_EN
  , parameter logic [15:0] RETRY_WAIT = 16'd50_000
`endif
) (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        recal,
  input  logic        meas_done,
  input  logic [11:0] meas_div,
  output logic        meas_rst_n,
  output logic [3:0]  val_div,
  output logic [11:0] baud_div,
  output logic        baud_lock,
  output logic        baud_err,
  output logic        busy
);

  localparam int unsigned DATA_W = 12;
  localparam int unsigned SUM_W  = DATA_W + NB_MEAS_LOG2;
  localparam int unsigned CNT_W  = NB_MEAS_LOG2 + 1;
  localparam logic [CNT_W-1:0] NB_MEAS = CNT_W'(1 << NB_MEAS_LOG2);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, ACC, CHECK, LOCK, ERR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_arm_cnt;
  logic [23:0]         r_to_cnt;
  logic                r_done_d;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_sample;
  logic [SUM_W-1:0]    r_sum;
  logic [DATA_W-1:0]   r_min;
  logic [DATA_W-1:0]   r_max;
  logic                w_done_rise;
  logic                w_last;
  logic                w_clear;
  logic                w_pass;
  logic [DATA_W-1:0]   w_avg;
  logic [DATA_W-1:0]   w_spread;
  logic                w_retry_done;

  function automatic logic [DATA_W-1:0] f_avg(input logic [SUM_W-1:0] sum);
    return DATA_W'(sum >> NB_MEAS_LOG2);
  endfunction

  assign w_done_rise = meas_done && !r_done_d;
  assign w_last      = (r_cnt + CNT_W'(1)) == NB_MEAS;
  assign w_avg       = f_avg(r_sum);
  assign w_spread    = r_max - r_min;
  assign w_pass      = (w_spread <= TOL) && (w_avg >= MIN_DIV);
  // Restarting from a resting state or any recal discards partial results
  assign w_clear     = recal ||
                       ((r_state == IDLE || r_state == LOCK || r_state == ERR) && w_state_nxt == ARM);

`ifdef RS232_BAUD_CTRL_AUTORETRY_EN
  logic [15:0] r_retry_cnt;

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst)                    r_retry_cnt <= '0;
    else if (r_state == ERR)    r_retry_cnt <= r_retry_cnt + 16'd1;
    else                        r_retry_cnt <= '0;
  end

  assign w_retry_done = (r_state == ERR) && (r_retry_cnt == RETRY_WAIT - 16'd1);
`else
  assign w_retry_done = 1'b0;
`endif

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (recal) begin
      w_state_nxt = ARM;
    end else begin
      case (r_state)
        IDLE:    if (AUTO_START) w_state_nxt = ARM;
        ARM:     if (r_arm_cnt) w_state_nxt = WAIT;
        WAIT: begin
          if (w_done_rise)                        w_state_nxt = ACC;
          else if (r_to_cnt == TIMEOUT - 24'd1)   w_state_nxt = ERR;
        end
        ACC:     w_state_nxt = w_last ? CHECK : ARM;
        CHECK:   w_state_nxt = w_pass ? LOCK : ERR;
        LOCK:    w_state_nxt = LOCK;
        ERR:     if (w_retry_done) w_state_nxt = ARM;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    meas_rst_n = !(r_state == IDLE || r_state == ARM);
    busy       = (r_state == ARM) || (r_state == WAIT) || (r_state == ACC) || (r_state == CHECK);
    val_div    = PRESC;
  end

  // Control: ARM pulse width, timeout, edge detect, sample count
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_arm_cnt <= 1'b0;
      r_to_cnt  <= '0;
      r_done_d  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_arm_cnt <= (r_state == ARM) && !recal && !r_arm_cnt;
      r_to_cnt  <= (r_state == WAIT) ? r_to_cnt + 24'd1 : '0;
      r_done_d  <= meas_done;
      if (w_clear)               r_cnt <= '0;
      else if (r_state == ACC)   r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_ref) begin
    if (r_state == WAIT && w_done_rise) r_sample <= meas_div;
    if (w_clear) begin
      r_sum <= '0;
      r_min <= '1;
      r_max <= '0;
    end else if (r_state == ACC) begin
      r_sum <= r_sum + SUM_W'(r_sample);
      if (r_sample < r_min) r_min <= r_sample;
      if (r_sample > r_max) r_max <= r_sample;
    end
  end

  // Published results; baud_div survives recal and failed calibrations
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      baud_div  <= '0;
      baud_lock <= 1'b0;
      baud_err  <= 1'b0;
    end else begin
      if (r_state == CHECK && w_state_nxt == LOCK) baud_div <= w_avg;
      if (w_state_nxt == ARM)                               baud_lock <= 1'b0;
      else if (r_state == CHECK && w_state_nxt == LOCK)     baud_lock <= 1'b1;
      if (w_state_nxt == ARM)                               baud_err <= 1'b0;
      else if (r_state != ERR && w_state_nxt == ERR)        baud_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rs232_baud_ctrl.sv
// Self-checking bench for rs232_baud_ctrl; stands in for the measurement core and compares
// against an arithmetic reference of the calibration outcome.
module tb_rs232_baud_ctrl;

  localparam int PRESC_I = 3;
  localparam int TOL_I   = 2;
  localparam int MIND_I  = 4;
  localparam int TO_I    = 1000;
  localparam int RETRY_I = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        recal = 1'b0;
  logic        meas_done = 1'b0;
  logic [11:0] meas_div = '0;
  logic        meas_rst_n;
  logic [3:0]  val_div;
  logic [11:0] baud_div;
  logic        baud_lock;
  logic        baud_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_div = '0;

  rs232_baud_ctrl #(
    .NB_MEAS_LOG2(2), .PRESC(4'd3), .TOL(12'd2), .MIN_DIV(12'd4),
    .TIMEOUT(24'd1000), .AUTO_START(1'b1)
`ifdef RS232_BAUD_CTRL_AUTORETRY_EN
    , .RETRY_WAIT(16'd100)
`endif
  ) dut (
    .clk_ref(clk), .rst(rst), .recal(recal), .meas_done(meas_done), .meas_div(meas_div),
    .meas_rst_n(meas_rst_n), .val_div(val_div), .baud_div(baud_div),
    .baud_lock(baud_lock), .baud_err(baud_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start-bit width in clocks to the core's measured divisor
  function automatic logic [11:0] width2div(input int w);
    return 12'(w / (PRESC_I + 1));
  endfunction

  function automatic void ref_cal(input logic [11:0] s [4], output bit pass, output logic [11:0] avg);
    int sum, mn, mx;
    sum = 0; mn = 4095; mx = 0;
    foreach (s[i]) begin
      sum += int'(s[i]);
      if (int'(s[i]) < mn) mn = int'(s[i]);
      if (int'(s[i]) > mx) mx = int'(s[i]);
    end
    avg  = 12'(sum / 4);
    pass = ((mx - mn) <= TOL_I) && (sum / 4 >= MIND_I);
  endfunction

  task automatic wait_wait_state(input string name);
    int n = 0;
    while (meas_rst_n !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (meas_rst_n !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_reach_wait: meas_rst_n=%b busy=%b, required 1/1", name, meas_rst_n, busy);
    end
  endtask

  task automatic do_sample(input logic [11:0] v, input bit last, input string name);
    wait_wait_state(name);
    repeat ($urandom_range(0, 5)) tick();
    meas_div  = v;
    meas_done = 1'b1;
    tick();
    tick();
    meas_done = 1'b0;
    if (!last) begin
      checks++;
      if (meas_rst_n !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL %s_arm1: meas_rst_n=%b busy=%b, required 0/1", name, meas_rst_n, busy);
      end
      tick();
      checks++;
      if (meas_rst_n !== 1'b0) begin errors++; $display("FAIL %s_arm2: meas_rst_n=%b, required 0", name, meas_rst_n); end
      tick();
      checks++;
      if (meas_rst_n !== 1'b1) begin errors++; $display("FAIL %s_arm_end: meas_rst_n=%b, required 1", name, meas_rst_n); end
    end
  endtask

  task automatic run_cal(input logic [11:0] s [4], input string name);
    bit pass;
    logic [11:0] avg;
    ref_cal(s, pass, avg);
    for (int i = 0; i < 4; i++) do_sample(s[i], i == 3, name);
    checks++;
    if (baud_lock !== 1'b0 || baud_err !== 1'b0) begin
      errors++; $display("FAIL %s_early: lock=%b err=%b one cycle after final edge, required 0/0", name, baud_lock, baud_err);
    end
    tick();
    if (pass) exp_div = avg;
    checks++;
    if (baud_lock !== pass || baud_err !== !pass || baud_div !== exp_div || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: lock=%b err=%b div=%0d busy=%b, required %b/%b/%0d/0",
               name, baud_lock, baud_err, baud_div, busy, pass, !pass, exp_div);
    end
  endtask

  task automatic start_cal(input string name);
    recal = 1'b1;
    tick();
    recal = 1'b0;
    checks++;
    if (busy !== 1'b1 || baud_lock !== 1'b0 || baud_err !== 1'b0 || meas_rst_n !== 1'b0 || baud_div !== exp_div) begin
      errors++;
      $display("FAIL %s_recal: busy=%b lock=%b err=%b rst_n=%b div=%0d, required 1/0/0/0/%0d",
               name, busy, baud_lock, baud_err, meas_rst_n, baud_div, exp_div);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (meas_rst_n !== 1'b0 || val_div !== 4'(PRESC_I) || baud_div !== 12'd0 ||
        baud_lock !== 1'b0 || baud_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: rst_n=%b val_div=%0d div=%0d lock=%b err=%b busy=%b, required 0/%0d/0/0/0/0",
               name, meas_rst_n, val_div, baud_div, baud_lock, baud_err, busy, PRESC_I);
    end
  endtask

  task automatic test_reset();
    #3;
    check_reset_outputs("reset_async");
    tick(); tick();
    check_reset_outputs("reset_held");
    rst = 1'b0;
    exp_div = '0;
    tick();
    checks++;
    if (busy !== 1'b1 || meas_rst_n !== 1'b0) begin
      errors++; $display("FAIL autostart: busy=%b rst_n=%b, required 1/0", busy, meas_rst_n);
    end
  endtask

  task automatic test_spread_err();
    logic [11:0] s [4] = '{12'd108, 12'd108, 12'd112, 12'd108};
    run_cal(s, "spread");
  endtask

  task automatic test_lock_and_recal();
    logic [11:0] s [4];
    s = '{width2div(432), width2div(432), width2div(436), width2div(432)};
    start_cal("lock108");
    run_cal(s, "lock108");
    start_cal("hold108");
    s = '{width2div(216), width2div(216), width2div(218), width2div(216)};
    run_cal(s, "lock54");
  endtask

  task automatic test_boundaries();
    logic [11:0] t [4][4];
    t[0] = '{12'd108, 12'd110, 12'd109, 12'd108};
    t[1] = '{12'd4, 12'd4, 12'd4, 12'd4};
    t[2] = '{12'd3, 12'd3, 12'd3, 12'd4};
    t[3] = '{12'd4095, 12'd4094, 12'd4093, 12'd4095};
    for (int i = 0; i < 4; i++) begin
      start_cal("bound");
      run_cal(t[i], $sformatf("bound%0d", i));
    end
  endtask

  task automatic test_random();
    logic [11:0] s [4];
    int base, spr;
    for (int n = 0; n < 8; n++) begin
      base = $urandom_range(2, 300);
      spr  = $urandom_range(0, 4);
      foreach (s[i]) s[i] = 12'(base + $urandom_range(0, spr));
      start_cal("rand");
      run_cal(s, $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_abort();
    logic [11:0] s [4] = '{12'd77, 12'd78, 12'd77, 12'd77};
    start_cal("abort");
    do_sample(12'd60, 1'b0, "abort_pre");
    do_sample(12'd61, 1'b0, "abort_pre");
    wait_wait_state("abort");
    repeat ($urandom_range(0, 5)) tick();
    meas_div  = 12'd200;
    meas_done = 1'b1;
    recal     = 1'b1;
    tick();
    recal = 1'b0;
    checks++;
    if (meas_rst_n !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_arm1: rst_n=%b busy=%b, required 0/1", meas_rst_n, busy);
    end
    tick();
    meas_done = 1'b0;
    checks++;
    if (meas_rst_n !== 1'b0) begin errors++; $display("FAIL abort_arm2: rst_n=%b, required 0", meas_rst_n); end
    tick();
    checks++;
    if (meas_rst_n !== 1'b1) begin errors++; $display("FAIL abort_arm_end: rst_n=%b, required 1", meas_rst_n); end
    run_cal(s, "abort_after");
  endtask

  task automatic test_timeout();
    start_cal("timeout");
    wait_wait_state("timeout");
    repeat (TO_I - 1) tick();
    checks++;
    if (baud_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early: err=%b busy=%b, required 0/1", baud_err, busy);
    end
    tick();
    checks++;
    if (baud_err !== 1'b1 || busy !== 1'b0 || baud_lock !== 1'b0 || baud_div !== exp_div) begin
      errors++; $display("FAIL timeout_err: err=%b busy=%b lock=%b div=%0d, required 1/0/0/%0d",
                         baud_err, busy, baud_lock, baud_div, exp_div);
    end
`ifdef RS232_BAUD_CTRL_AUTORETRY_EN
    repeat (RETRY_I - 1) tick();
    checks++;
    if (busy !== 1'b0 || baud_err !== 1'b1) begin
      errors++; $display("FAIL retry_early: busy=%b err=%b, required 0/1", busy, baud_err);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || baud_err !== 1'b0) begin
      errors++; $display("FAIL retry_rearm: busy=%b err=%b, required 1/0", busy, baud_err);
    end
`else
    repeat (RETRY_I + 50) tick();
    checks++;
    if (busy !== 1'b0 || baud_err !== 1'b1) begin
      errors++; $display("FAIL err_hold: busy=%b err=%b, required 0/1", busy, baud_err);
    end
`endif
  endtask

  task automatic test_rst_in_wait();
    start_cal("rstwait");
    wait_wait_state("rstwait");
    #2;
    rst = 1'b1;
    #1;
    exp_div = '0;
    check_reset_outputs("rst_in_wait");
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_idle: busy=%b, required 0", busy); end
    tick();
    checks++;
    if (busy !== 1'b1 || meas_rst_n !== 1'b0) begin
      errors++; $display("FAIL rst_autostart: busy=%b rst_n=%b, required 1/0", busy, meas_rst_n);
    end
  endtask

  initial begin
    test_reset();
    test_spread_err();
    test_lock_and_recal();
    test_boundaries();
    test_random();
    test_abort();
    test_timeout();
    test_rst_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
